image_ram_reader: RTL and testbench
===================================

// Module: image_ram_reader
// PURPOSE
//  Upstream feeder of the IM2COL stage. Streams one image (width*height*channel bytes,
//  raster order, channel-minor) from a synchronous image BRAM.
//  Transfers run while the IM2COL enable (o_en_ram) is high.
//  Drives the i_ram_to_i2c_data/_valid/i_ram_read_done inputs of IM2COL.
// PARAMETERS
//  DATA_SIZE    8   element width, bits (signed)
//  ADDR_WIDTH   16  BRAM address width
//  RAM_LATENCY  1   BRAM read latency in cycles; legal values 1 or 2
// PORTS
//  i_clk            in   1            clock
//  i_n_reset        in   1            asynchronous, active-low reset
//  i_set_param      in   1            latch geometry/base; accepted only in IDLE
//  i_image_width    in   8            pixels per row
//  i_image_height   in   8            rows
//  i_image_channel  in   8            channels
//  i_base_addr      in   ADDR_WIDTH   BRAM address of first element
//  i_en_ram         in   1            read enable from IM2COL o_en_ram
//  o_bram_en        out  1            BRAM read strobe
//  o_bram_addr      out  ADDR_WIDTH   BRAM read address
//  i_bram_rdata     in   DATA_SIZE    BRAM read data, valid RAM_LATENCY after o_bram_en
//  o_data           out  DATA_SIZE    signed element to IM2COL
//  o_valid          out  1            o_data valid, one element per cycle
//  o_ram_read_done  out  1            image fully delivered (level)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters, latched params and in-flight pipe cleared.
//  Reset mid-transfer aborts the transfer. In-flight data is discarded.
//  Param latch: in IDLE, i_set_param=1 latches w,h,c,base and
//   total = w*h*c (24-bit, no overflow).
//  i_set_param outside IDLE is ignored.
//  FSM IDLE -> READ when i_en_ram=1 and total!=0.
//  IDLE -> DONE when i_en_ram=1 and total==0; no BRAM access is made.
//  READ: each cycle with i_en_ram=1, issue o_bram_en=1 and o_bram_addr=base+idx, then idx++.
//   Address is base+idx truncated to ADDR_WIDTH; it wraps silently.
//   i_en_ram=0 pauses issue (o_bram_en=0). Already-issued reads still emerge as o_valid.
//   After issuing idx==total-1 -> DRAIN.
//  DRAIN: no issue; wait until the in-flight pipe is empty, then -> DONE.
//  DONE: o_ram_read_done=1; it holds until i_en_ram=0, then -> IDLE with idx cleared.
//  Latency: o_valid/o_data registered. They follow the matching o_bram_en by exactly
//   RAM_LATENCY+1 cycles.
//   A valid shift register of depth RAM_LATENCY tracks in-flight reads.
//  Exactly total o_valid pulses per image, in address order. No gaps except those
//   caused by i_en_ram pauses.
//  o_ram_read_done rises the cycle after the last o_valid. It never overlaps o_valid.
//  The next image can start in IDLE via a new i_set_param or by re-asserting i_en_ram
//   (same params).
// CONFIGURATION
//  `IMG_READER_ZERO_POINT_EN defined:
//   - adds input i_zero_point [DATA_SIZE-1:0] signed, latched with i_set_param;
//   - o_data = sat(rdata - zero_point) to the signed DATA_SIZE range, computed in
//     DATA_SIZE+1 bits;
//   - latency unchanged.
//  Not defined: port absent; o_data = i_bram_rdata unmodified.
// STRUCTURE
//  Shared package npu_pkg:
//   - FSM state encoding (IDLE, READ, DRAIN, DONE);
//   - width of total/idx (24);
//   - localparam SAT_MAX/SAT_MIN derived from DATA_SIZE.
//  One sub-module rd_valid_pipe (parameterised RAM_LATENCY-deep valid shift register
//   with an empty flag).
//  Address counter, FSM and output register stay in the top module.
// TESTING
//  1 4x4x1, base=0x0010, BRAM[a]=a-0x10, i_en_ram held high -> 16 o_valid with data
//    0..15 contiguous, first o_valid RAM_LATENCY+1 after first o_bram_en;
//    o_ram_read_done one cycle after the 16th; addresses 0x10..0x1F.
//  2 Same image, drop i_en_ram for 3 cycles after 5 issues -> o_bram_en=0 during the
//    pause; in-flight data still arrives; 16 total, order intact; no duplicates.
//  3 total==0 (width=0), i_en_ram=1 -> no o_bram_en; o_ram_read_done=1 next cycle;
//    cleared after i_en_ram=0.
//  4 Assert i_n_reset low mid-READ (after 7 elements) -> all outputs 0 immediately.
//    A rerun then yields 16 fresh elements from index 0.
//  5 i_set_param with new width=2 during READ -> ignored; the current image completes
//    with 16 elements.
//  6 With IMG_READER_ZERO_POINT_EN, zero_point=-100, rdata=+100 -> o_data=+127
//    (saturated). zero_point=100, rdata=-100 -> -128. zero_point=3, rdata=10 -> 7.

Source files
------------

// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared types and constants for the image RAM reader
package npu_pkg;

  // Reader sequencing: IDLE -> READ -> DRAIN -> DONE -> IDLE
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

  // Element count / index width; 8x8x8-bit geometry fits without overflow
  localparam int CNT_WIDTH = 24;

  // Default element width and its signed saturation bounds
  localparam int DEF_DATA_SIZE = 8;

  function automatic int sat_max_of(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int sat_min_of(input int width);
    return -(1 << (width - 1));
  endfunction

  localparam int SAT_MAX = sat_max_of(DEF_DATA_SIZE);
  localparam int SAT_MIN = sat_min_of(DEF_DATA_SIZE);

endpackage

// File: rtl/image_ram_reader_if.sv
// rtl/image_ram_reader_if.sv - BRAM read port and IM2COL feed bundle
interface image_ram_reader_if #(
  parameter int DATA_SIZE  = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                         i_en_ram;
  logic                         o_bram_en;
  logic [ADDR_WIDTH-1:0]        o_bram_addr;
  logic [DATA_SIZE-1:0]         i_bram_rdata;
  logic signed [DATA_SIZE-1:0]  o_data;
  logic                         o_valid;
  logic                         o_ram_read_done;

  // Reader side
  modport master (
    input  i_en_ram, i_bram_rdata,
    output o_bram_en, o_bram_addr, o_data, o_valid, o_ram_read_done
  );

  // BRAM / IM2COL side
  modport slave (
    output i_en_ram, i_bram_rdata,
    input  o_bram_en, o_bram_addr, o_data, o_valid, o_ram_read_done
  );
endinterface

// File: rtl/image_ram_reader_rd_valid_pipe.sv
// rtl/image_ram_reader_rd_valid_pipe.sv - in-flight BRAM read tracker with empty flag
module rd_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic i_clk,
  input  logic i_n_reset,
  input  logic i_valid,
  output logic o_valid,
  output logic o_empty
);

  logic [DEPTH-1:0] pipe_q;

  if (DEPTH == 1) begin : g_one
    // Single-stage tracker for a one-cycle BRAM
    always_ff @(posedge i_clk or negedge i_n_reset) begin
      if (!i_n_reset) pipe_q <= '0;
      else            pipe_q <= i_valid;
    end
  end else begin : g_multi
    // Shift issued strobes forward; the top bit marks read data present now
    always_ff @(posedge i_clk or negedge i_n_reset) begin
      if (!i_n_reset) pipe_q <= '0;
      else            pipe_q <= {pipe_q[DEPTH-2:0], i_valid};
    end
  end

  assign o_valid = pipe_q[DEPTH-1];
  assign o_empty = ~|pipe_q;

endmodule

// File: rtl/image_ram_reader.sv
// rtl/image_ram_reader.sv - streams one image from BRAM to IM2COL; option IMG_READER_ZERO_POINT_EN
module image_ram_reader
  import npu_pkg::*;
#(
  parameter int DATA_SIZE   = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int RAM_LATENCY = 1
) (
  input  logic                         i_clk,
  input  logic                         i_n_reset,
  input  logic                         i_set_param,
  input  logic [7:0]                   i_image_width,
  input  logic [7:0]                   i_image_height,
  input  logic [7:0]                   i_image_channel,
  input  logic [ADDR_WIDTH-1:0]        i_base_addr,
`ifdef IMG_READER_ZERO_POINT_EN
  input  logic signed [DATA_SIZE-1:0]  i_zero_point,
`endif
  image_ram_reader_if.master           bus
);

  rd_state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0]    idx_q, total_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic                    param_we, issue, last_issue;
  logic                    rdata_valid, pipe_empty;
  logic                    valid_q;
  logic [DATA_SIZE-1:0]    data_q, elem;

  assign param_we   = (state_q == ST_IDLE) && i_set_param;
  assign issue      = (state_q == ST_READ) && bus.i_en_ram;
  assign last_issue = issue && (idx_q == total_q - CNT_WIDTH'(1));

  // Geometry and base are frozen outside IDLE so a running image cannot be disturbed
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      total_q <= '0;
      base_q  <= '0;
    end else if (param_we) begin
      total_q <= CNT_WIDTH'(i_image_width) * CNT_WIDTH'(i_image_height)
               * CNT_WIDTH'(i_image_channel);
      base_q  <= i_base_addr;
    end
  end

  // Element index advances on each issued read and rewinds when the image is handed off
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      idx_q <= '0;
    end else if ((state_q == ST_DONE) && !bus.i_en_ram) begin
      idx_q <= '0;
    end else if (issue) begin
      idx_q <= idx_q + CNT_WIDTH'(1);
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state: empty images skip straight to DONE; DRAIN waits for outstanding reads
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.i_en_ram) state_d = (total_q == '0) ? ST_DONE : ST_READ;
      ST_READ:  if (last_issue)   state_d = ST_DRAIN;
      ST_DRAIN: if (pipe_empty)   state_d = ST_DONE;
      ST_DONE:  if (!bus.i_en_ram) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  rd_valid_pipe #(
    .DEPTH (RAM_LATENCY)
  ) u_rd_valid_pipe (
    .i_clk     (i_clk),
    .i_n_reset (i_n_reset),
    .i_valid   (issue),
    .o_valid   (rdata_valid),
    .o_empty   (pipe_empty)
  );

`ifdef IMG_READER_ZERO_POINT_EN
  localparam logic signed [DATA_SIZE:0] SAT_HI = (DATA_SIZE+1)'(sat_max_of(DATA_SIZE));
  localparam logic signed [DATA_SIZE:0] SAT_LO = (DATA_SIZE+1)'(sat_min_of(DATA_SIZE));

  logic signed [DATA_SIZE-1:0] zp_q;
  logic signed [DATA_SIZE:0]   diff;

  // Zero point is part of the image parameters and latches with them
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset)    zp_q <= '0;
    else if (param_we) zp_q <= i_zero_point;
  end

  // One extra bit holds any difference of two signed elements; clamp back to range
  always_comb begin
    diff = $signed({bus.i_bram_rdata[DATA_SIZE-1], bus.i_bram_rdata})
         - $signed({zp_q[DATA_SIZE-1], zp_q});
    if (diff > SAT_HI)      elem = SAT_HI[DATA_SIZE-1:0];
    else if (diff < SAT_LO) elem = SAT_LO[DATA_SIZE-1:0];
    else                    elem = diff[DATA_SIZE-1:0];
  end
`else
  assign elem = bus.i_bram_rdata;
`endif

  // Registered output stage: adds the one cycle on top of the BRAM latency
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= rdata_valid;
      if (rdata_valid) data_q <= elem;
    end
  end

  assign bus.o_bram_en       = issue;
  assign bus.o_bram_addr     = issue ? (base_q + ADDR_WIDTH'(idx_q)) : '0;
  assign bus.o_valid         = valid_q;
  assign bus.o_data          = data_q;
  assign bus.o_ram_read_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_image_ram_reader.sv
// tb/tb_image_ram_reader.sv - self-checking bench for image_ram_reader
module tb_image_ram_reader;
  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          set_param;
  logic [7:0]    w, h, c;
  logic [AW-1:0] base;
`ifdef IMG_READER_ZERO_POINT_EN
  logic signed [DW-1:0] zp;
  int zp_next  = 0;
  int model_zp = 0;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  image_ram_reader_if #(.DATA_SIZE(DW), .ADDR_WIDTH(AW)) bus ();

  image_ram_reader #(.DATA_SIZE(DW), .ADDR_WIDTH(AW), .RAM_LATENCY(LAT)) dut (
    .i_clk           (clk),
    .i_n_reset       (rst_n),
    .i_set_param     (set_param),
    .i_image_width   (w),
    .i_image_height  (h),
    .i_image_channel (c),
    .i_base_addr     (base),
`ifdef IMG_READER_ZERO_POINT_EN
    .i_zero_point    (zp),
`endif
    .bus             (bus)
  );

  // BRAM model with LAT cycles of read latency
  logic [7:0] mem [0:65535];
  logic [7:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (bus.o_bram_en) rd_pipe[0] <= mem[bus.o_bram_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.i_bram_rdata = rd_pipe[LAT-1];

  // Observation
  int         iss_cyc_q[$];
  logic [15:0] addr_q[$];
  logic [7:0]  data_q[$];
  int lat_err, ovl_err, pause_err;
  int first_valid_cyc, last_valid_cyc, done_rise_cyc;
  bit prev_done;
  int ic;

  always @(negedge clk) begin
    if (bus.o_bram_en) begin
      addr_q.push_back(bus.o_bram_addr);
      iss_cyc_q.push_back(cyc);
      if (!bus.i_en_ram) pause_err++;
    end
    if (bus.o_valid) begin
      data_q.push_back(bus.o_data);
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      last_valid_cyc = cyc;
      if (iss_cyc_q.size() == 0) lat_err++;
      else begin
        ic = iss_cyc_q.pop_front();
        if (cyc - ic != LAT + 1) lat_err++;
      end
    end
    if (bus.o_valid && bus.o_ram_read_done) ovl_err++;
    if (bus.o_ram_read_done && !prev_done && done_rise_cyc < 0) done_rise_cyc = cyc;
    prev_done = bus.o_ram_read_done;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference element: raw byte, or byte minus zero point clamped to int8
  function automatic logic [7:0] exp_elem(input logic [15:0] a);
`ifdef IMG_READER_ZERO_POINT_EN
    int d;
    d = int'($signed(mem[a])) - model_zp;
    if (d > 127)  d = 127;
    if (d < -128) d = -128;
    return 8'(d);
`else
    return mem[a];
`endif
  endfunction

  task automatic clear_mon();
    iss_cyc_q.delete(); addr_q.delete(); data_q.delete();
    lat_err = 0; ovl_err = 0; pause_err = 0;
    first_valid_cyc = -1; last_valid_cyc = -1; done_rise_cyc = -1;
  endtask

  task automatic set_params(input int w_, input int h_, input int c_, input logic [15:0] b_);
    @(posedge clk); #1;
    w = 8'(w_); h = 8'(h_); c = 8'(c_); base = b_;
`ifdef IMG_READER_ZERO_POINT_EN
    zp = 8'(zp_next); model_zp = zp_next;
`endif
    set_param = 1'b1;
    @(posedge clk); #1;
    set_param = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_bram_en"}, bus.o_bram_en, 0);
    check({name, "_bram_addr"}, bus.o_bram_addr, 0);
    check({name, "_valid"}, bus.o_valid, 0);
    check({name, "_data"}, bus.o_data, 0);
    check({name, "_done"}, bus.o_ram_read_done, 0);
  endtask

  task automatic run_image(input string name, input int w_, input int h_, input int c_,
                           input logic [15:0] b_, input int pause_at, input int pause_len,
                           input bit mid_set, input bit rnd_en, input int exp_total);
    int tot, budget, pause_rem, en_rise, bad_d, bad_a, n;
    bit done_seen, paused, set_done;
    logic [7:0]  ed[$];
    logic [15:0] ea[$];
    set_params(w_, h_, c_, b_);
    tot = w_ * h_ * c_;
    for (int i = 0; i < tot; i++) begin
      ea.push_back(16'(int'(b_) + i));
      ed.push_back(exp_elem(16'(int'(b_) + i)));
    end
    clear_mon();
    done_seen = 0; paused = 0; set_done = 0; pause_rem = 0; budget = 0;
    @(posedge clk); #1;
    bus.i_en_ram = 1'b1;
    en_rise = cyc;
    while (!done_seen && budget < 3000) begin
      @(negedge clk); #1;
      budget++;
      if (bus.o_ram_read_done) done_seen = 1;
      else begin
        if (!paused && pause_at >= 0 && addr_q.size() == pause_at) begin
          paused = 1; pause_rem = pause_len;
        end
        @(posedge clk); #1;
        set_param = 1'b0;
        if (mid_set && !set_done && addr_q.size() >= 3) begin
          set_done = 1; set_param = 1'b1; w = 8'd2;
        end
        if (rnd_en) begin
          bus.i_en_ram = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 15) == 0) begin
            set_param = 1'b1; w = 8'($urandom); h = 8'($urandom); base = 16'($urandom);
          end
        end else if (pause_rem > 0) begin
          bus.i_en_ram = 1'b0; pause_rem--;
        end else begin
          bus.i_en_ram = 1'b1;
        end
      end
    end
    check({name, "_done_seen"}, done_seen, 1);
    @(posedge clk); #1;
    bus.i_en_ram = 1'b0; set_param = 1'b0;
    @(posedge clk); #1;
    check({name, "_done_cleared"}, bus.o_ram_read_done, 0);
    check({name, "_issues"}, addr_q.size(), exp_total);
    check({name, "_valids"}, data_q.size(), exp_total);
    bad_d = 0; bad_a = 0;
    n = (data_q.size() < tot) ? data_q.size() : tot;
    for (int i = 0; i < n; i++) if (data_q[i] !== ed[i]) bad_d++;
    bad_d += (data_q.size() > tot) ? data_q.size() - tot : tot - data_q.size();
    n = (addr_q.size() < tot) ? addr_q.size() : tot;
    for (int i = 0; i < n; i++) if (addr_q[i] !== ea[i]) bad_a++;
    bad_a += (addr_q.size() > tot) ? addr_q.size() - tot : tot - addr_q.size();
    check({name, "_data_errs"}, bad_d, 0);
    check({name, "_addr_errs"}, bad_a, 0);
    check({name, "_latency_errs"}, lat_err, 0);
    check({name, "_overlap_errs"}, ovl_err, 0);
    check({name, "_issue_while_paused"}, pause_err, 0);
    if (tot > 0) check({name, "_done_rise"}, done_rise_cyc, last_valid_cyc + 1);
    else         check({name, "_done_rise"}, done_rise_cyc, en_rise + 1);
    if (!rnd_en && pause_len == 0 && tot > 0)
      check({name, "_contiguous"}, last_valid_cyc - first_valid_cyc, tot - 1);
  endtask

  typedef struct {
    string       name;
    int          w, h, c;
    logic [15:0] base;
    int          pause_at, pause_len;
    bit          mid_set;
    int          exp_total;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int budget;
    tbl[0] = '{"img4x4",     4, 4, 1, 16'h0010, -1, 0, 1'b0, 16};
    tbl[1] = '{"pause",      4, 4, 1, 16'h0010,  5, 3, 1'b0, 16};
    tbl[2] = '{"zero_total", 0, 4, 1, 16'h0010, -1, 0, 1'b0,  0};
    tbl[3] = '{"mid_set",    4, 4, 1, 16'h0010, -1, 0, 1'b1, 16};
    tbl[4] = '{"wrap",       3, 2, 4, 16'hFFF8, -1, 0, 1'b0, 24};
    tbl[5] = '{"single",     1, 1, 1, 16'h1234, -1, 0, 1'b0,  1};
    tbl[6] = '{"pause_long", 5, 3, 2, 16'h0100,  7, 4, 1'b0, 30};

    for (int a = 0; a < 65536; a++) mem[a] = (a < 256) ? 8'(a - 16) : 8'($urandom);
    for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
    clear_mon();
    prev_done = 1'b0;

    rst_n = 1'b0; set_param = 1'b0; bus.i_en_ram = 1'b0;
    w = '0; h = '0; c = '0; base = '0;
`ifdef IMG_READER_ZERO_POINT_EN
    zp = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_image(tbl[i].name, tbl[i].w, tbl[i].h, tbl[i].c, tbl[i].base,
                tbl[i].pause_at, tbl[i].pause_len, tbl[i].mid_set, 1'b0, tbl[i].exp_total);

    // Reset in the middle of READ, then a clean rerun from index 0
    set_params(4, 4, 1, 16'h0010);
    clear_mon();
    @(posedge clk); #1;
    bus.i_en_ram = 1'b1;
    budget = 0;
    while (data_q.size() < 7 && budget < 200) begin
      @(negedge clk); #1;
      budget++;
    end
    check("midreset_reached_7", data_q.size() >= 7, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(posedge clk); #1;
    bus.i_en_ram = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_image("reset_rerun", 4, 4, 1, 16'h0010, -1, 0, 1'b0, 1'b0, 16);

`ifdef IMG_READER_ZERO_POINT_EN
    mem[16'h2000] = 8'd100;
    mem[16'h2001] = 8'h9C;
    mem[16'h2002] = 8'd10;
    zp_next = -100;
    run_image("zp_hi", 1, 1, 1, 16'h2000, -1, 0, 1'b0, 1'b0, 1);
    check("zp_hi_value", (data_q.size() > 0) ? longint'($signed(data_q[0])) : 999, 127);
    zp_next = 100;
    run_image("zp_lo", 1, 1, 1, 16'h2001, -1, 0, 1'b0, 1'b0, 1);
    check("zp_lo_value", (data_q.size() > 0) ? longint'($signed(data_q[0])) : 999, -128);
    zp_next = 3;
    run_image("zp_mid", 1, 1, 1, 16'h2002, -1, 0, 1'b0, 1'b0, 1);
    check("zp_mid_value", (data_q.size() > 0) ? longint'($signed(data_q[0])) : 999, 7);
`endif

    // Randomized geometry, base and enable pattern against the reference model
    for (int r = 0; r < 8; r++) begin
      int rw, rh, rc;
      rw = $urandom_range(0, 6);
      rh = $urandom_range(1, 5);
      rc = $urandom_range(1, 3);
`ifdef IMG_READER_ZERO_POINT_EN
      zp_next = $urandom_range(0, 255) - 128;
`endif
      run_image($sformatf("rand%0d", r), rw, rh, rc, 16'($urandom), -1, 0, 1'b0, 1'b1,
                rw * rh * rc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
